regfile_2r1w: RTL and testbench

Parametrised successor to the team's 8x16 one-read/one-write register file, for the next datapath revision. Two independent combinational read ports and one clocked write port. Adds:
- per-entry valid tracking;
- optional write-to-read bypass;
- a sequential clear sweep that zeroes storage one entry per cycle after reset or on request, with `busy` and write-drop reporting.

---
 rtl/regfile_2r1w.sv | 119 +++++++++++
 tb/tb_regfile_2r1w.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with per-entry valid bits, optional write-to-read bypass and a one-entry-per-cycle clear sweep.
// Reads are combinational (0 cycles) and writes are readable next cycle; there is no backpressure, so writes during a clear or sweep are dropped and flagged on write_err.
module regfile_2r1w #(
  parameter int WIDTH  = 16,
  parameter int AW     = 3,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    writenum,
  input  logic             write,
  input  logic             clear,
  input  logic [AW-1:0]    readnum_a,
  input  logic [AW-1:0]    readnum_b,
  output logic [WIDTH-1:0] data_out_a,
  output logic [WIDTH-1:0] data_out_b,
  output logic             valid_a,
  output logic             valid_b,
  output logic             busy,
  output logic             write_err
);

  localparam int            DEPTH  = 2**AW;
  localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);
  localparam bit            BYP_EN = (BYPASS != 0);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    idx, idx_nxt;
  logic             wr_ok, wr_drop;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] vld;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= SWEEP;
      idx       <= '0;
      write_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      write_err <= wr_drop;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wr_ok     = 1'b0;
    wr_drop   = 1'b0;
    case (state)
      IDLE: begin
        if (clear) begin
          state_nxt = SWEEP;
          idx_nxt   = '0;
          wr_drop   = write;
        end else begin
          wr_ok = write;
        end
      end
      SWEEP: begin
        wr_drop = write;
        if (clear) begin
          idx_nxt = '0;
        end else begin
          idx_nxt = idx + 1'b1;
          if (idx == LAST) state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = SWEEP;
        idx_nxt   = '0;
      end
    endcase
  end

  // Storage is not reset directly; the sweep that follows reset zeroes it.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (state == SWEEP) mem[idx] <= '0;
      else if (wr_ok)     mem[writenum] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)                    vld <= '0;
    else if (state == IDLE && clear) vld <= '0;
    else if (wr_ok)                  vld[writenum] <= 1'b1;
  end

  assign busy = (state == SWEEP);

  always_comb begin
    data_out_a = '0;
    valid_a    = 1'b0;
    if (BYP_EN && wr_ok && writenum == readnum_a) begin
      data_out_a = data_in;
      valid_a    = 1'b1;
    end else if (vld[readnum_a]) begin
      data_out_a = mem[readnum_a];
      valid_a    = 1'b1;
    end
  end

  always_comb begin
    data_out_b = '0;
    valid_b    = 1'b0;
    if (BYP_EN && wr_ok && writenum == readnum_b) begin
      data_out_b = data_in;
      valid_b    = 1'b1;
    end else if (vld[readnum_b]) begin
      data_out_b = mem[readnum_b];
      valid_b    = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed table of per-cycle vectors against a bypass and a non-bypass instance, plus hand-written drop/sweep sequences.
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        reset_n, write, clear;
  logic [15:0] data_in;
  logic [2:0]  writenum, readnum_a, readnum_b;
  logic [15:0] da, db, nda, ndb;
  logic        va, vb, nva, nvb;
  logic        busy, werr, nbusy, nwerr;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  regfile_2r1w #(.WIDTH(16), .AW(3), .BYPASS(1)) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .writenum(writenum),
    .write(write), .clear(clear), .readnum_a(readnum_a), .readnum_b(readnum_b),
    .data_out_a(da), .data_out_b(db), .valid_a(va), .valid_b(vb),
    .busy(busy), .write_err(werr)
  );

  regfile_2r1w #(.WIDTH(16), .AW(3), .BYPASS(0)) dut_nb (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .writenum(writenum),
    .write(write), .clear(clear), .readnum_a(readnum_a), .readnum_b(readnum_b),
    .data_out_a(nda), .data_out_b(ndb), .valid_a(nva), .valid_b(nvb),
    .busy(nbusy), .write_err(nwerr)
  );

  typedef struct {
    logic        rst_n, clr, wr;
    logic [2:0]  wn;
    logic [15:0] din;
    logic [2:0]  ra, rb;
    logic [15:0] da, db, nda, ndb;
    logic        va, vb, nva, nvb;
    logic        busy, werr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst_n, input logic clr, input logic wr,
                     input logic [2:0] wn, input logic [15:0] din,
                     input logic [2:0] ra, input logic [2:0] rb,
                     input logic [15:0] eda, input logic eva,
                     input logic [15:0] edb, input logic evb,
                     input logic ebusy, input logic ewerr);
    vec_t v;
    v.rst_n = rst_n; v.clr = clr; v.wr = wr; v.wn = wn; v.din = din;
    v.ra = ra; v.rb = rb;
    v.da = eda; v.va = eva; v.db = edb; v.vb = evb;
    v.nda = eda; v.nva = eva; v.ndb = edb; v.nvb = evb;
    v.busy = ebusy; v.werr = ewerr;
    tbl.push_back(v);
  endtask

  // Override the non-bypass expectation of the most recently added row.
  task automatic nb(input logic [15:0] eda, input logic eva,
                    input logic [15:0] edb, input logic evb);
    int k;
    k = tbl.size() - 1;
    tbl[k].nda = eda; tbl[k].nva = eva; tbl[k].ndb = edb; tbl[k].nvb = evb;
  endtask

  task automatic cmp(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s row %0d: got %h, expected %h", nm, row, act, exp);
    end
  endtask

  task automatic idle_in();
    write = 1'b0; clear = 1'b0; reset_n = 1'b1; writenum = '0; data_in = '0;
  endtask

  initial begin
    int cnt;
    int guard;

    reset_n = 1'b0; clear = 1'b0; write = 1'b0;
    writenum = '0; data_in = '0; readnum_a = '0; readnum_b = '0;

    // Reset held for two edges (initial edge plus row 0), then an 8-cycle sweep.
    add(0,0,0,3'd0,16'h0, 3'd0,3'd7, 16'h0,0, 16'h0,0, 1,0);
    for (int i = 0; i < 8; i++) add(1,0,0,3'd0,16'h0, 3'(i),3'd4, 16'h0,0, 16'h0,0, 1,0);

    // Basic write/read.
    add(1,0,1,3'd3,16'hBEEF, 3'd3,3'd5, 16'hBEEF,1, 16'h0,0, 0,0); nb(16'h0,0, 16'h0,0);
    add(1,0,1,3'd5,16'h1234, 3'd3,3'd5, 16'hBEEF,1, 16'h1234,1, 0,0); nb(16'hBEEF,1, 16'h0,0);
    add(1,0,0,3'd0,16'h0, 3'd3,3'd5, 16'hBEEF,1, 16'h1234,1, 0,0);
    add(1,0,0,3'd0,16'h0, 3'd4,3'd4, 16'h0,0, 16'h0,0, 0,0);

    // Bypass versus registered read on entry 2.
    add(1,0,1,3'd2,16'hA5A5, 3'd2,3'd2, 16'hA5A5,1, 16'hA5A5,1, 0,0); nb(16'h0,0, 16'h0,0);
    add(1,0,1,3'd2,16'h5A5A, 3'd2,3'd2, 16'h5A5A,1, 16'h5A5A,1, 0,0); nb(16'hA5A5,1, 16'hA5A5,1);
    add(1,0,0,3'd0,16'h0, 3'd2,3'd3, 16'h5A5A,1, 16'hBEEF,1, 0,0);

    // Clear, then a write on the 3rd busy cycle is dropped.
    add(1,1,0,3'd0,16'h0, 3'd2,3'd5, 16'h5A5A,1, 16'h1234,1, 0,0);
    add(1,0,0,3'd0,16'h0, 3'd2,3'd5, 16'h0,0, 16'h0,0, 1,0);
    add(1,0,0,3'd0,16'h0, 3'd2,3'd5, 16'h0,0, 16'h0,0, 1,0);
    add(1,0,1,3'd1,16'h7777, 3'd1,3'd1, 16'h0,0, 16'h0,0, 1,0);
    add(1,0,0,3'd0,16'h0, 3'd1,3'd1, 16'h0,0, 16'h0,0, 1,1);
    for (int i = 0; i < 4; i++) add(1,0,0,3'd0,16'h0, 3'd1,3'd1, 16'h0,0, 16'h0,0, 1,0);
    add(1,0,0,3'd0,16'h0, 3'd1,3'd3, 16'h0,0, 16'h0,0, 0,0);

    // Clear with simultaneous write, then restart 4 cycles later: 12 busy cycles.
    add(1,1,1,3'd6,16'hFFFF, 3'd6,3'd6, 16'h0,0, 16'h0,0, 0,0);
    add(1,0,0,3'd0,16'h0, 3'd6,3'd6, 16'h0,0, 16'h0,0, 1,1);
    add(1,0,0,3'd0,16'h0, 3'd6,3'd6, 16'h0,0, 16'h0,0, 1,0);
    add(1,0,0,3'd0,16'h0, 3'd6,3'd6, 16'h0,0, 16'h0,0, 1,0);
    add(1,1,0,3'd0,16'h0, 3'd6,3'd6, 16'h0,0, 16'h0,0, 1,0);
    for (int i = 0; i < 8; i++) add(1,0,0,3'd0,16'h0, 3'd6,3'd6, 16'h0,0, 16'h0,0, 1,0);
    add(1,0,0,3'd0,16'h0, 3'd6,3'd6, 16'h0,0, 16'h0,0, 0,0);

    // Fill all entries, clear, reset on the 5th busy cycle with a write pending.
    for (int i = 0; i < 8; i++) begin
      add(1,0,1,3'(i),16'(16'h1000 + i), 3'(i),3'd0, 16'(16'h1000 + i),1, 16'h1000,1, 0,0);
      if (i == 0) nb(16'h0,0, 16'h0,0);
      else        nb(16'h0,0, 16'h1000,1);
    end
    add(1,0,0,3'd0,16'h0, 3'd0,3'd7, 16'h1000,1, 16'h1007,1, 0,0);
    add(1,1,0,3'd0,16'h0, 3'd0,3'd7, 16'h1000,1, 16'h1007,1, 0,0);
    for (int i = 0; i < 4; i++) add(1,0,0,3'd0,16'h0, 3'd0,3'd7, 16'h0,0, 16'h0,0, 1,0);
    add(0,0,1,3'd3,16'h3333, 3'd0,3'd7, 16'h0,0, 16'h0,0, 1,0);
    for (int i = 0; i < 8; i++) add(1,0,0,3'd0,16'h0, 3'd0,3'd7, 16'h0,0, 16'h0,0, 1,0);
    add(1,0,0,3'd0,16'h0, 3'd0,3'd7, 16'h0,0, 16'h0,0, 0,0);

    foreach (tbl[i]) begin
      @(negedge clk);
      reset_n = tbl[i].rst_n; clear = tbl[i].clr; write = tbl[i].wr;
      writenum = tbl[i].wn; data_in = tbl[i].din;
      readnum_a = tbl[i].ra; readnum_b = tbl[i].rb;
      #1;
      cmp("data_out_a", i, da, tbl[i].da);
      cmp("valid_a",    i, {15'h0, va}, {15'h0, tbl[i].va});
      cmp("data_out_b", i, db, tbl[i].db);
      cmp("valid_b",    i, {15'h0, vb}, {15'h0, tbl[i].vb});
      cmp("busy",       i, {15'h0, busy}, {15'h0, tbl[i].busy});
      cmp("write_err",  i, {15'h0, werr}, {15'h0, tbl[i].werr});
      cmp("nb data_out_a", i, nda, tbl[i].nda);
      cmp("nb valid_a",    i, {15'h0, nva}, {15'h0, tbl[i].nva});
      cmp("nb data_out_b", i, ndb, tbl[i].ndb);
      cmp("nb valid_b",    i, {15'h0, nvb}, {15'h0, tbl[i].nvb});
      cmp("nb busy",       i, {15'h0, nbusy}, {15'h0, tbl[i].busy});
      cmp("nb write_err",  i, {15'h0, nwerr}, {15'h0, tbl[i].werr});
    end

    // Back-to-back drops (clear+write, then write in sweep) keep write_err high for two cycles.
    @(negedge clk);
    idle_in(); write = 1'b1; writenum = 3'd1; data_in = 16'h1111; readnum_a = 3'd1; readnum_b = 3'd1;
    @(negedge clk);
    idle_in();
    #1;
    cmp("seq stored", 1000, nda, 16'h1111);
    cmp("seq stored valid", 1000, {15'h0, nva}, 16'h1);
    @(negedge clk);
    clear = 1'b1; write = 1'b1; writenum = 3'd1; data_in = 16'h2222;
    @(negedge clk);
    clear = 1'b0;
    #1;
    cmp("seq werr 1st", 1001, {15'h0, werr}, 16'h1);
    cmp("seq busy 1st", 1001, {15'h0, busy}, 16'h1);
    @(negedge clk);
    write = 1'b0;
    #1;
    cmp("seq werr 2nd", 1002, {15'h0, werr}, 16'h1);
    @(negedge clk);
    #1;
    cmp("seq werr end", 1003, {15'h0, werr}, 16'h0);

    // Busy count from the 3rd busy cycle to the end of the sweep, bounded.
    cnt = 0;
    guard = 0;
    while (busy === 1'b1 && guard < 40) begin
      cnt++;
      guard++;
      @(negedge clk);
      #1;
    end
    cmp("seq busy remaining", 1004, 16'(cnt), 16'd6);
    cmp("seq entry1 data", 1005, da, 16'h0);
    cmp("seq entry1 valid", 1005, {15'h0, va}, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
